data_memory_responder: RTL and testbench

//  Data-memory responder for the multi-cycle core: accepts load/store requests issued by the

---
 rtl/data_memory_responder_if.sv | 19 +
 rtl/data_memory_responder.sv | 92 +++++++++
 tb/tb_data_memory_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response bus between the core sequencer and the data-memory responder
// master: drives req_valid/req_write/req_funct3/req_addr/req_wdata; samples req_ready/resp_*/busy
// slave : the responder side of the same signals
interface data_memory_responder_if #(parameter int WORDSIZE = 64);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [2:0]          req_funct3;
  logic [WORDSIZE-1:0] req_addr;
  logic [WORDSIZE-1:0] req_wdata;
  logic                resp_valid;
  logic [WORDSIZE-1:0] resp_rdata;
  logic                resp_error;
  logic                busy;
  modport master(output req_valid, req_write, req_funct3, req_addr, req_wdata,
                 input req_ready, resp_valid, resp_rdata, resp_error, busy);
  modport slave(input req_valid, req_write, req_funct3, req_addr, req_wdata,
                output req_ready, resp_valid, resp_rdata, resp_error, busy);
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency RV64 load/store responder over a doubleword-organised RAM
// ports: clk, rst (sync, active-high), bus (data_memory_responder_if.slave: req_* in, req_ready/resp_*/busy out)
// option: DMEM_MISALIGN_TRAP_EN turns misaligned accesses into error responses instead of truncating the offset
module data_memory_responder #(
  parameter int WORDSIZE  = 64,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 2
) (
  input logic clk,
  input logic rst,
  data_memory_responder_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0]          cnt;
  logic                write_q;
  logic [2:0]          f3_q;
  logic [WORDSIZE-1:0] addr_q, wdata_q;
  logic [WORDSIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic [2:0]          off, amask, off_al;
  logic [1:0]          sz;
  logic [5:0]          sh;
  logic                sgn, mis, err, fire;
  logic [7:0]          be;
  logic [63:0]         bm, rw, ld, wv;
  // the cast drops the ignored upper address bits, giving the modulo-depth wrap
  assign idx    = ADDR_W'(addr_q >> 3);
  assign off    = addr_q[2:0];
  assign sz     = f3_q[1:0];
  assign sgn    = ~f3_q[2];
  assign amask  = ~((3'd1 << sz) - 3'd1);
  assign mis    = |(off & ~amask);
  assign off_al = off & amask;
  assign sh     = {off_al, 3'b000};
`ifdef DMEM_MISALIGN_TRAP_EN
  assign err    = (write_q ? f3_q[2] : &f3_q) | mis;
`else
  assign err    = write_q ? f3_q[2] : &f3_q;
`endif
  assign rw     = mem[idx] >> sh;
  assign ld     = sz == 2'd0 ? {{56{sgn & rw[7]}}, rw[7:0]} :
                  sz == 2'd1 ? {{48{sgn & rw[15]}}, rw[15:0]} :
                  sz == 2'd2 ? {{32{sgn & rw[31]}}, rw[31:0]} : rw;
  assign be     = 8'((sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF) << off_al);
  for (genvar i = 0; i < 8; i++) begin : g_bm
    assign bm[8*i +: 8] = {8{be[i]}};
  end
  assign wv     = (mem[idx] & ~bm) | ((wdata_q << sh) & bm);
  assign fire   = state == WAIT && cnt == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          write_q       <= bus.req_write;
          f3_q          <= bus.req_funct3;
          addr_q        <= bus.req_addr;
          wdata_q       <= bus.req_wdata;
          cnt           <= 4'(LATENCY - 1);
          bus.req_ready <= 1'b0;
          bus.busy      <= 1'b1;
          state         <= WAIT;
        end
        WAIT: if (cnt == 4'd0) begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= (write_q | err) ? '0 : ld;
          bus.resp_error <= err;
          state          <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst && fire && write_q && !err) mem[idx] <= wv;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed table, reset-abort sequence and randomized traffic against a byte-array model
module tb_data_memory_responder;
  localparam int LATENCY = 2;
  logic clk = 0, rst = 1;
  int passed = 0, total = 0;
  logic [7:0] mb [2048];
  always #5 clk = ~clk;
  data_memory_responder_if #(.WORDSIZE(64)) bus ();
  data_memory_responder #(.WORDSIZE(64), .MEM_DEPTH(256), .LATENCY(LATENCY)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit          w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    bit          err;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask
  task automatic model(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output bit e);
    int sz, off, base;
    sz = 1 << f3[1:0];
    off = int'(a[2:0]);
    e = w ? f3[2] : (f3 == 3'd7);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (off % sz != 0) e = 1;
`endif
    base = int'(a[10:0]) - (off % sz);
    rd = 0;
    if (!e) begin
      if (w) for (int k = 0; k < sz; k++) mb[base + k] = wd[8*k +: 8];
      else begin
        for (int k = 0; k < sz; k++) rd[8*k +: 8] = mb[base + k];
        if (!f3[2] && rd[8*sz-1]) for (int k = sz; k < 8; k++) rd[8*k +: 8] = 8'hFF;
      end
    end
  endtask
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output bit e);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_write = w; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.req_write = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = {$urandom, $urandom}; bus.req_wdata = {$urandom, $urandom};
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.resp_valid && n < 40);
    chk("latency", 64'(n), 64'(LATENCY));
    rd = bus.resp_rdata; e = bus.resp_error;
    @(posedge clk); #1;
    chk("single_pulse", bus.resp_valid, 0);
    chk("ready_after_resp", bus.req_ready, 1);
  endtask
  initial begin
    logic [63:0] rd, mrd;
    bit e, me;
    bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    for (int i = 0; i < 256; i++) begin
      logic [63:0] d = {$urandom, $urandom};
      model(1, 3'd3, 64'(i * 8), d, mrd, me);
      do_req(1, 3'd3, 64'(i * 8), d, rd, e);
    end
    tbl.push_back(vec_t'{1, 3'd3, 64'h10, 64'h8000_0000_0000_00FF, 64'h0, 0});
    tbl.push_back(vec_t'{0, 3'd3, 64'h10, 64'h0, 64'h8000_0000_0000_00FF, 0});
    tbl.push_back(vec_t'{0, 3'd0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0});
    tbl.push_back(vec_t'{0, 3'd4, 64'h10, 64'h0, 64'hFF, 0});
    tbl.push_back(vec_t'{0, 3'd2, 64'h14, 64'h0, 64'hFFFF_FFFF_8000_0000, 0});
    tbl.push_back(vec_t'{0, 3'd6, 64'h14, 64'h0, 64'h8000_0000, 0});
    tbl.push_back(vec_t'{1, 3'd0, 64'h11, 64'hAB, 64'h0, 0});
    tbl.push_back(vec_t'{0, 3'd3, 64'h10, 64'h0, 64'h8000_0000_0000_ABFF, 0});
    tbl.push_back(vec_t'{0, 3'd7, 64'h10, 64'h0, 64'h0, 1});
    tbl.push_back(vec_t'{1, 3'd4, 64'h10, 64'h1234, 64'h0, 1});
    tbl.push_back(vec_t'{0, 3'd1, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl.push_back(vec_t'{1, 3'd2, 64'h12, 64'h1122_3344, 64'h0, 1});
    tbl.push_back(vec_t'{0, 3'd3, 64'h10, 64'h0, 64'h8000_0000_0000_ABFF, 0});
`else
    tbl.push_back(vec_t'{1, 3'd2, 64'h12, 64'h1122_3344, 64'h0, 0});
    tbl.push_back(vec_t'{0, 3'd3, 64'h10, 64'h0, 64'h8000_0000_1122_3344, 0});
`endif
    tbl.push_back(vec_t'{1, 3'd3, 64'h800, 64'hCAFE_F00D_1234_5678, 64'h0, 0});
    tbl.push_back(vec_t'{0, 3'd3, 64'h0, 64'h0, 64'hCAFE_F00D_1234_5678, 0});
    tbl.push_back(vec_t'{1, 3'd3, 64'h20, 64'h5555_AAAA_0000_5555, 64'h0, 0});
    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, me);
      do_req(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, e);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d_error", i), e, tbl[i].err);
    end
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_funct3 = 3'd3; bus.req_addr = 64'h20; bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk("abort_busy", bus.busy, 1);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("abort_no_resp", bus.resp_valid, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    chk("abort_valid", bus.resp_valid, 0);
    chk("abort_idle", bus.busy, 0);
    chk("abort_ready", bus.req_ready, 1);
    do_req(0, 3'd3, 64'h20, 64'h0, rd, e);
    chk("abort_ram_kept", rd, 64'h5555_AAAA_0000_5555);
    for (int i = 0; i < 300; i++) begin
      bit w = 1'($urandom);
      logic [2:0] f3 = 3'($urandom);
      logic [63:0] a = {$urandom, $urandom};
      logic [63:0] d = {$urandom, $urandom};
      model(w, f3, a, d, mrd, me);
      do_req(w, f3, a, d, rd, e);
      chk("rand_rdata", rd, mrd);
      chk("rand_error", e, me);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
